// File: rtl/pll_seq_pkg.sv
// PLL bring-up sequencer: shared types and defaults.
// State encoding, default parameters, counter width helper.
package pll_seq_pkg;

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_ASSERT    = 3'd1,
      S_WAIT_LOCK = 3'd2,
      S_STABLE    = 3'd3,
      S_RUN       = 3'd4,
      S_FAULT     = 3'd5
   } pll_state_e;

   localparam int unsigned DEF_RST_CYCLES   = 16;
   localparam int unsigned DEF_LOCK_TIMEOUT = 4096;
   localparam int unsigned DEF_LOCK_STABLE  = 64;
   localparam int unsigned DEF_MAX_RETRY    = 3;

   // Bits needed to hold the largest of three cycle counts.
   function automatic int unsigned cnt_width(
      input int unsigned a,
      input int unsigned b,
      input int unsigned c
   );
      int unsigned m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      return (m < 2) ? 1 : $clog2(m + 1);
   endfunction

endpackage

// File: rtl/pll_lock_sync.sv
// PLL bring-up sequencer: lock flag synchronizer.
// Two flops, both cleared by the synchronous reset.
module pll_lock_sync (
   input  logic clk,
   input  logic rst,
   input  logic async_in,
   output logic sync_out
);

   logic meta_q, meta_d;
   logic sync_q, sync_d;

   // Shift the asynchronous flag through two stages.
   always_comb begin
      meta_d = async_in;
      sync_d = meta_q;
   end

   // Synchronizer registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
      end
   end

   assign sync_out = sync_q;

endmodule

// File: rtl/pll_seq_ctrl.sv
// PLL bring-up sequencer: FSM, counters and registered outputs.
// Holds the PLL in reset, waits for stable lock, retries on timeout.
module pll_seq_ctrl
   import pll_seq_pkg::*;
#(
   parameter int unsigned RST_CYCLES   = DEF_RST_CYCLES,
   parameter int unsigned LOCK_TIMEOUT = DEF_LOCK_TIMEOUT,
   parameter int unsigned LOCK_STABLE  = DEF_LOCK_STABLE,
   parameter int unsigned MAX_RETRY    = DEF_MAX_RETRY
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       enable,
   input  logic       pll_locked,
   output logic       pll_areset,
   output logic       sys_rst_n,
   output logic       ready,
   output logic       fault,
   output logic [1:0] retry_cnt,
   output logic       lock_lost,
   output logic [2:0] state
);

   localparam int unsigned CW =
      cnt_width(RST_CYCLES, LOCK_TIMEOUT, LOCK_STABLE);

   localparam logic [CW-1:0] RST_LAST  = CW'(RST_CYCLES - 1);
   localparam logic [CW-1:0] TO_LAST   = CW'(LOCK_TIMEOUT - 1);
   localparam logic [CW-1:0] STAB_LAST = CW'(LOCK_STABLE - 1);
   localparam logic [CW-1:0] CNT_MAX   = '1;
   localparam logic [1:0]    RETRY_MAX = 2'(MAX_RETRY);

   pll_state_e    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
   logic [1:0]    retry_q, retry_d;
   logic          lost_q, lost_d;
   logic          areset_q, areset_d;
   logic          srst_n_q, srst_n_d;
   logic          ready_q, ready_d;
   logic          fault_q, fault_d;
   logic          lock_s;

   pll_lock_sync u_sync (
      .clk      (clk),
      .rst      (rst),
      .async_in (pll_locked),
      .sync_out (lock_s)
   );

   // Next state, counter, retry and sticky-loss logic.
   always_comb begin
      state_d = state_q;
      retry_d = retry_q;
      lost_d  = lost_q;
      cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
      cnt_d   = cnt_inc;

      unique case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            if (enable) begin
               state_d = S_ASSERT;
               retry_d = 2'd0;
            end
         end
         S_ASSERT: begin
            if (cnt_q >= RST_LAST) state_d = S_WAIT_LOCK;
         end
         S_WAIT_LOCK: begin
            if (lock_s) begin
               state_d = S_STABLE;
            end else if (cnt_q >= TO_LAST) begin
               if (retry_q < RETRY_MAX) begin
                  retry_d = retry_q + 2'd1;
                  state_d = S_ASSERT;
               end else begin
                  state_d = S_FAULT;
               end
            end
         end
         S_STABLE: begin
            if (!lock_s) begin
               state_d = S_WAIT_LOCK;
            end else if (cnt_q >= STAB_LAST) begin
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            cnt_d = '0;
            if (!lock_s) begin
               state_d = S_ASSERT;
               lost_d  = 1'b1;
               retry_d = 2'd0;
            end
         end
         S_FAULT: begin
            cnt_d = '0;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      if (!enable) state_d = S_IDLE;
      if (state_d != state_q) cnt_d = '0;
      if (state_d == S_IDLE) begin
         lost_d  = 1'b0;
         retry_d = 2'd0;
      end
   end

   // Output decode from the state being entered, so the registered
   // outputs always line up with the state register.
   always_comb begin
      areset_d = 1'b1;
      srst_n_d = 1'b0;
      ready_d  = 1'b0;
      fault_d  = 1'b0;
      unique case (state_d)
         S_WAIT_LOCK,
         S_STABLE: areset_d = 1'b0;
         S_RUN: begin
            areset_d = 1'b0;
            srst_n_d = 1'b1;
            ready_d  = 1'b1;
         end
         S_FAULT: fault_d = 1'b1;
         default: areset_d = 1'b1;
      endcase
   end

   // State, counters and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         retry_q  <= 2'd0;
         lost_q   <= 1'b0;
         areset_q <= 1'b1;
         srst_n_q <= 1'b0;
         ready_q  <= 1'b0;
         fault_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         retry_q  <= retry_d;
         lost_q   <= lost_d;
         areset_q <= areset_d;
         srst_n_q <= srst_n_d;
         ready_q  <= ready_d;
         fault_q  <= fault_d;
      end
   end

   assign pll_areset = areset_q;
   assign sys_rst_n  = srst_n_q;
   assign ready      = ready_q;
   assign fault      = fault_q;
   assign retry_cnt  = retry_q;
   assign lock_lost  = lost_q;
   assign state      = state_q;

endmodule

// File: tb/tb_pll_seq_ctrl.sv
// Testbench for pll_seq_ctrl.
// Table of directed vectors plus hand-written multi-cycle sequences.
module tb_pll_seq_ctrl;

   logic       clk;
   logic       rst;
   logic       enable;
   logic       pll_locked;
   logic       pll_areset;
   logic       sys_rst_n;
   logic       ready;
   logic       fault;
   logic [1:0] retry_cnt;
   logic       lock_lost;
   logic [2:0] state;

   int checks = 0;
   int errors = 0;

   pll_seq_ctrl #(
      .RST_CYCLES   (4),
      .LOCK_TIMEOUT (32),
      .LOCK_STABLE  (8),
      .MAX_RETRY    (2)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .enable     (enable),
      .pll_locked (pll_locked),
      .pll_areset (pll_areset),
      .sys_rst_n  (sys_rst_n),
      .ready      (ready),
      .fault      (fault),
      .retry_cnt  (retry_cnt),
      .lock_lost  (lock_lost),
      .state      (state)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic       rst;
      logic       en;
      logic       lock;
      int         n;
      logic [2:0] st;
      logic       ar;
      logic       sr;
      logic       rdy;
      logic       flt;
      logic [1:0] rc;
      logic       ll;
   } vec_t;

   localparam int NV = 21;
   vec_t tv [NV];

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0d want %0d", nm, act, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
         chk("srst_rel_during_areset", 32'(sys_rst_n & pll_areset), 0);
      end
   endtask

   task automatic chk_all(input string tag, input logic [2:0] st,
                          input logic ar, input logic sr,
                          input logic rdy, input logic flt,
                          input logic [1:0] rc, input logic ll);
      chk({tag, ".state"}, 32'(state), 32'(st));
      chk({tag, ".pll_areset"}, 32'(pll_areset), 32'(ar));
      chk({tag, ".sys_rst_n"}, 32'(sys_rst_n), 32'(sr));
      chk({tag, ".ready"}, 32'(ready), 32'(rdy));
      chk({tag, ".fault"}, 32'(fault), 32'(flt));
      chk({tag, ".retry_cnt"}, 32'(retry_cnt), 32'(rc));
      chk({tag, ".lock_lost"}, 32'(lock_lost), 32'(ll));
   endtask

   task automatic do_reset();
      rst        = 1'b1;
      enable     = 1'b0;
      pll_locked = 1'b0;
      step(1);
      rst = 1'b0;
   endtask

   initial begin
      rst        = 1'b1;
      enable     = 1'b0;
      pll_locked = 1'b0;

      // rst en lk  n  st ar sr rdy flt rc ll
      tv[0]  = '{1, 0, 0, 1, 3'd0, 1, 0, 0, 0, 2'd0, 0};
      tv[1]  = '{0, 1, 0, 1, 3'd1, 1, 0, 0, 0, 2'd0, 0};
      tv[2]  = '{0, 1, 0, 3, 3'd1, 1, 0, 0, 0, 2'd0, 0};
      tv[3]  = '{0, 1, 0, 1, 3'd2, 0, 0, 0, 0, 2'd0, 0};
      tv[4]  = '{0, 1, 0, 9, 3'd2, 0, 0, 0, 0, 2'd0, 0};
      tv[5]  = '{0, 1, 1, 2, 3'd2, 0, 0, 0, 0, 2'd0, 0};
      tv[6]  = '{0, 1, 1, 1, 3'd3, 0, 0, 0, 0, 2'd0, 0};
      tv[7]  = '{0, 1, 1, 7, 3'd3, 0, 0, 0, 0, 2'd0, 0};
      tv[8]  = '{0, 1, 1, 1, 3'd4, 0, 1, 1, 0, 2'd0, 0};
      tv[9]  = '{0, 1, 1, 5, 3'd4, 0, 1, 1, 0, 2'd0, 0};
      tv[10] = '{0, 1, 0, 2, 3'd4, 0, 1, 1, 0, 2'd0, 0};
      tv[11] = '{0, 1, 0, 1, 3'd1, 1, 0, 0, 0, 2'd0, 1};
      tv[12] = '{0, 1, 1, 3, 3'd1, 1, 0, 0, 0, 2'd0, 1};
      tv[13] = '{0, 1, 1, 1, 3'd2, 0, 0, 0, 0, 2'd0, 1};
      tv[14] = '{0, 1, 1, 1, 3'd3, 0, 0, 0, 0, 2'd0, 1};
      tv[15] = '{0, 1, 1, 7, 3'd3, 0, 0, 0, 0, 2'd0, 1};
      tv[16] = '{0, 1, 1, 1, 3'd4, 0, 1, 1, 0, 2'd0, 1};
      tv[17] = '{1, 1, 1, 1, 3'd0, 1, 0, 0, 0, 2'd0, 0};
      tv[18] = '{0, 1, 0, 1, 3'd1, 1, 0, 0, 0, 2'd0, 0};
      tv[19] = '{0, 1, 0, 4, 3'd2, 0, 0, 0, 0, 2'd0, 0};
      tv[20] = '{0, 0, 0, 1, 3'd0, 1, 0, 0, 0, 2'd0, 0};

      @(posedge clk);
      #1;
      for (int i = 0; i < NV; i++) begin
         rst        = tv[i].rst;
         enable     = tv[i].en;
         pll_locked = tv[i].lock;
         step(tv[i].n);
         chk_all($sformatf("vec%0d", i), tv[i].st, tv[i].ar,
                 tv[i].sr, tv[i].rdy, tv[i].flt, tv[i].rc, tv[i].ll);
      end

      // One-cycle lock glitch after five stable cycles.
      do_reset();
      enable     = 1'b1;
      pll_locked = 1'b1;
      step(5);
      chk_all("gl_wait", 3'd2, 0, 0, 0, 0, 2'd0, 0);
      step(1);
      chk_all("gl_stable", 3'd3, 0, 0, 0, 0, 2'd0, 0);
      step(3);
      pll_locked = 1'b0;
      step(1);
      pll_locked = 1'b1;
      step(1);
      chk("gl_still_stable", 32'(state), 3);
      step(1);
      chk_all("gl_back_wait", 3'd2, 0, 0, 0, 0, 2'd0, 0);
      step(1);
      chk("gl_restable", 32'(state), 3);
      step(7);
      chk("gl_not_run_early", 32'(state), 3);
      step(1);
      chk_all("gl_run", 3'd4, 0, 1, 1, 0, 2'd0, 0);

      // Lock never arrives: three attempts, then FAULT.
      do_reset();
      enable     = 1'b1;
      pll_locked = 1'b0;
      step(1);
      chk_all("to_a0", 3'd1, 1, 0, 0, 0, 2'd0, 0);
      step(4);
      chk_all("to_w0", 3'd2, 0, 0, 0, 0, 2'd0, 0);
      step(31);
      chk("to_w0_end", 32'(state), 2);
      step(1);
      chk_all("to_a1", 3'd1, 1, 0, 0, 0, 2'd1, 0);
      step(3);
      chk("to_a1_end", 32'(pll_areset), 1);
      step(1);
      chk_all("to_w1", 3'd2, 0, 0, 0, 0, 2'd1, 0);
      step(31);
      chk("to_w1_end", 32'(state), 2);
      step(1);
      chk_all("to_a2", 3'd1, 1, 0, 0, 0, 2'd2, 0);
      step(4);
      chk_all("to_w2", 3'd2, 0, 0, 0, 0, 2'd2, 0);
      step(31);
      chk("to_w2_end", 32'(state), 2);
      step(1);
      chk_all("to_fault", 3'd5, 1, 0, 0, 1, 2'd2, 0);
      pll_locked = 1'b1;
      step(12);
      chk_all("to_fault_hold", 3'd5, 1, 0, 0, 1, 2'd2, 0);
      enable = 1'b0;
      step(1);
      chk_all("to_idle", 3'd0, 1, 0, 0, 0, 2'd0, 0);
      step(3);
      chk("idle_hold", 32'(state), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pll_seq_ctrl.md
PLL_SEQ_CTRL -- requirements
Module: pll_seq_ctrl

Interface
REQ-001 The block SHALL have parameter RST_CYCLES, default 16: number of cycles pll_areset is held high per reset attempt (minimum 1).
REQ-002 The block SHALL have parameter LOCK_TIMEOUT, default 4096: cycles allowed in WAIT_LOCK before an attempt fails.
REQ-003 The block SHALL have parameter LOCK_STABLE, default 64: consecutive synchronized-locked cycles required before release.
REQ-004 The block SHALL have parameter MAX_RETRY, default 3: failed attempts tolerated before FAULT (retry_cnt width 2).
REQ-005 The block SHALL have port clk, input, 1 bit: single system clock; every flop is clocked by clk.
REQ-006 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-007 The block SHALL have port enable, input, 1 bit: level request to bring up the PLL; low forces IDLE.
REQ-008 The block SHALL have port pll_locked, input, 1 bit: PLL locked flag, asynchronous to clk.
REQ-009 The block SHALL have port pll_areset, output, 1 bit: drives the PLL areset input, high = PLL held in reset.
REQ-010 The block SHALL have port sys_rst_n, output, 1 bit: active-low reset for the logic fed by the PLL clock.
REQ-011 The block SHALL have port ready, output, 1 bit: high only in RUN.
REQ-012 The block SHALL have port fault, output, 1 bit: high only in FAULT.
REQ-013 The block SHALL have port retry_cnt, output, 2 bits: failed attempts in the current bring-up.
REQ-014 The block SHALL have port lock_lost, output, 1 bit: sticky flag set on loss of lock in RUN; cleared by rst or by a transition to IDLE.
REQ-015 The block SHALL have port state, output, 3 bits: current FSM state encoding.

Function
REQ-016 pll_locked SHALL pass through a 2-flop synchronizer giving lock_s; all decisions use lock_s only, so lock latency is 2 cycles.
REQ-017 All outputs SHALL be registered and SHALL be decoded from the current state plus the counters.
REQ-018 The states SHALL be IDLE=0, ASSERT=1, WAIT_LOCK=2, STABLE=3, RUN=4, FAULT=5.
REQ-019 IDLE: pll_areset=1, sys_rst_n=0; enable=1 -> ASSERT with the cycle counter cleared and retry_cnt=0.
REQ-020 ASSERT: pll_areset=1 for exactly RST_CYCLES cycles, then -> WAIT_LOCK with the counter cleared.
REQ-021 WAIT_LOCK: pll_areset=0; lock_s=1 -> STABLE.
REQ-022 WAIT_LOCK timeout: when the counter reaches LOCK_TIMEOUT-1 with lock_s=0, retry_cnt<MAX_RETRY -> retry_cnt+1 and ASSERT; otherwise -> FAULT.
REQ-023 STABLE: counts consecutive lock_s=1; after LOCK_STABLE cycles -> RUN; any lock_s=0 -> WAIT_LOCK with the timeout counter restarted from 0.
REQ-024 RUN: sys_rst_n=1, ready=1; lock_s=0 -> ASSERT, set lock_lost, clear retry_cnt; sys_rst_n goes low on the first ASSERT cycle.
REQ-025 FAULT: pll_areset=1, sys_rst_n=0, fault=1; the block SHALL leave FAULT only by enable=0 (-> IDLE).
REQ-026 enable=0 SHALL force -> IDLE on the next edge from any state and SHALL take priority over every other transition.
REQ-027 sys_rst_n SHALL be 1 only in RUN; it SHALL never be 1 while pll_areset=1.
REQ-028 The counter SHALL be wide enough for max(RST_CYCLES, LOCK_TIMEOUT, LOCK_STABLE) and SHALL never wrap; it saturates and is cleared on every state change.

Reset
REQ-029 rst=1 at a clock edge SHALL force IDLE, counters=0, synchronizer=0, lock_lost=0, pll_areset=1, sys_rst_n=0, ready=0, fault=0, retry_cnt=0, state=0.
REQ-030 rst SHALL take priority over enable, including mid-sequence (e.g. during RUN or STABLE).

Structure
REQ-031 Package pll_seq_pkg SHALL hold the state encoding constants, the default parameter values and a clog2-based counter-width function.
REQ-032 The synchronizer SHALL be the sub-module pll_lock_sync (2-flop, reset to 0); the FSM and counters SHALL stay in pll_seq_ctrl.

Verification (RST_CYCLES=4, LOCK_TIMEOUT=32, LOCK_STABLE=8, MAX_RETRY=2)
REQ-033 Bring-up: enable=1, pll_locked rises 10 cycles after pll_areset falls -> pll_areset high 4 cycles, ready/sys_rst_n rise 2+8 cycles after lock (±1), retry_cnt=0.
REQ-034 Timeout retries: pll_locked held 0 -> three 4-cycle pll_areset pulses separated by 32-cycle waits, retry_cnt 0->1->2, then fault=1, state=5; enable=0 -> IDLE.
REQ-035 Glitch in STABLE: lock drops for 1 cycle after 5 stable cycles -> returns to WAIT_LOCK, and RUN is reached only 8 cycles after lock_s returns to 1.
REQ-036 Loss in RUN: pll_locked falls -> 2 cycles later ASSERT, sys_rst_n=0, ready=0, lock_lost=1, retry_cnt=0; relock -> RUN, lock_lost still 1.
REQ-037 Mid-operation: rst=1 in RUN -> next edge all outputs at reset values; enable=0 in WAIT_LOCK -> IDLE, pll_areset=1.
